// File: rtl/config_pkg.sv
// config_pkg: shared types, constants and tile geometry for the config menu
package config_pkg;
  localparam int NUM_ITEMS = 13;
  localparam int NUM_VALUES = 12;
  localparam int BUF_COLS = 40;
  localparam int START_ITEM = 12;
  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd8_t;
  typedef enum logic [1:0] {INIT, IDLE, WR_TENS, WR_ONES} state_t;
  function automatic logic [9:0] item_row(logic [3:0] i);
    return 10'd3 + {6'd0, i[2:0], 1'b0};
  endfunction
  function automatic logic [9:0] item_col(logic [3:0] i);
    return i[3] ? 10'd34 : 10'd14;
  endfunction
  function automatic logic [9:0] item_addr(logic [3:0] i, logic ones);
    logic [9:0] row;
    row = item_row(i);
    return (row << 5) + (row << 3) + item_col(i) + {9'd0, ones};
  endfunction
endpackage

// File: rtl/bcd_sat_step.sv
// bcd_sat_step: saturating 2-digit BCD increment/decrement
module bcd_sat_step
  import config_pkg::*;
(
  input  bcd8_t val,
  input  logic  inc,
  input  bcd8_t max,
  output bcd8_t nxt,
  output logic  changed
);
  bcd8_t up_val;
  bcd8_t dn_val;
  assign changed = inc ? (val < max) : (val != 8'h00);
  assign up_val = (val[3:0] == 4'd9) ? {val[7:4] + 4'd1, 4'd0} : {val[7:4], val[3:0] + 4'd1};
  assign dn_val = (val[3:0] == 4'd0) ? {val[7:4] - 4'd1, 4'd9} : {val[7:4], val[3:0] - 4'd1};
  assign nxt = !changed ? val : inc ? up_val : dn_val;
endmodule

// File: rtl/config_menu_ctrl.sv
// config_menu_ctrl: config screen cursor/value sequencer with tile buffer writes
module config_menu_ctrl
  import config_pkg::*;
#(
  parameter int         MAX_VAL    = 99,
  parameter logic [7:0] DIGIT_BASE = 8'h30,
  parameter int         INIT_VAL   = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_up_in,
  input  logic        btn_down_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        btn_sel_in,
  output logic [3:0]  ptr_index_out,
  output logic [95:0] values_out,
  output logic        start_out,
  output logic [9:0]  buf_write_addr_out,
  output logic [7:0]  buf_write_data_out,
  output logic        buf_write_en_out,
  output logic        busy_out
);
  localparam bcd8_t MAX_BCD = bcd8_t'((MAX_VAL / 10) * 16 + MAX_VAL % 10);
  localparam bcd8_t INIT_BCD = bcd8_t'((INIT_VAL / 10) * 16 + INIT_VAL % 10);
  localparam logic [3:0] LAST = 4'(START_ITEM);
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, cur_idx, init_item;
  bcd8_t vals [NUM_VALUES];
  bcd8_t vals_n [NUM_VALUES];
  logic [4:0] cnt, cnt_n;
  logic start, start_n, wr_en, wr_en_n;
  logic [9:0] wr_addr, wr_addr_n;
  logic [7:0] wr_data, wr_data_n;
  bcd8_t step_val;
  logic step_changed;
  assign cur_idx = (ptr < LAST) ? ptr : 4'd0;
  assign init_item = cnt[4:1];
  bcd_sat_step u_step (
    .val(vals[cur_idx]),
    .inc(~btn_left_in),
    .max(MAX_BCD),
    .nxt(step_val),
    .changed(step_changed)
  );
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= INIT;
      ptr <= 4'd0;
      vals <= '{default: INIT_BCD};
      cnt <= 5'd0;
      start <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= 10'd0;
      wr_data <= 8'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      vals <= vals_n;
      cnt <= cnt_n;
      start <= start_n;
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    vals_n = vals;
    cnt_n = cnt;
    start_n = 1'b0;
    wr_en_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    case (state)
      INIT: begin
        if (cnt == 5'd24) begin
          state_n = IDLE;
        end else begin
          wr_en_n = 1'b1;
          wr_addr_n = item_addr(init_item, cnt[0]);
          wr_data_n = DIGIT_BASE + {4'd0, cnt[0] ? vals[init_item][3:0] : vals[init_item][7:4]};
          cnt_n = cnt + 5'd1;
        end
      end
      IDLE: begin
        if (btn_up_in) ptr_n = (ptr == 4'd0) ? LAST : ptr - 4'd1;
        else if (btn_down_in) ptr_n = (ptr == LAST) ? 4'd0 : ptr + 4'd1;
        else if ((btn_left_in || btn_right_in) && ptr != LAST && step_changed) begin
          vals_n[cur_idx] = step_val;
          state_n = WR_TENS;
          wr_en_n = 1'b1;
          wr_addr_n = item_addr(cur_idx, 1'b0);
          wr_data_n = DIGIT_BASE + {4'd0, step_val[7:4]};
        end else if (btn_sel_in && ptr == LAST) start_n = 1'b1;
      end
      WR_TENS: begin
        state_n = WR_ONES;
        wr_en_n = 1'b1;
        wr_addr_n = wr_addr + 10'd1;
        wr_data_n = DIGIT_BASE + {4'd0, vals[cur_idx][3:0]};
      end
      default: state_n = IDLE;
    endcase
  end
  for (genvar i = 0; i < NUM_VALUES; i++) assign values_out[8*i +: 8] = vals[i];
  assign ptr_index_out = ptr;
  assign start_out = start;
  assign buf_write_addr_out = wr_addr;
  assign buf_write_data_out = wr_data;
  assign buf_write_en_out = wr_en;
  assign busy_out = (state != IDLE);
endmodule
